// File: rtl/fifo_nibble_packer.sv
// fifo_nibble_packer: drains a show-ahead nibble FIFO and packs NIBBLES
// nibbles, little-endian, into one wide word on a valid/ready output port.
// A flush request emits a zero-padded partial word once the FIFO is drained.
//
// Output handshake: a word is transferred at a rising clk edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0 the
// word (out_data/out_cnt/out_last) holds stable. out_valid never drops
// without an accept.
module fifo_nibble_packer #(
    parameter int  DATA_W  = 4,
    parameter int  NIBBLES = 4,
    localparam int CNT_W   = $clog2(NIBBLES + 1),
    localparam int WORD_W  = DATA_W * NIBBLES,
    localparam int ACC_W   = DATA_W * (NIBBLES - 1)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [15:0]       word_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NIBBLES);

    // Only the lower NIBBLES-1 nibbles are ever held; the final nibble of a
    // word goes straight from the FIFO head into the output register.
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             flush_pend;

    logic slot_free;
    logic at_last;
    logic pop;
    logic accept;
    logic word_done;
    logic flush_emit;
    logic flush_done;

    // Handshake and pop/flush decode from registered state and inputs.
    always_comb begin
        slot_free  = !out_valid || out_ready;
        at_last    = (cnt == LAST_IDX);
        pop        = rstN && !fifo_empty && (!at_last || slot_free);
        accept     = out_valid && out_ready;
        word_done  = pop && at_last;
        // Flush is only serviced once the FIFO has nothing left to pop.
        flush_emit = !pop && flush_pend && (cnt != '0) && slot_free;
        flush_done = !pop && flush_pend && ((cnt == '0) || slot_free);
        fifo_rd_en = pop;
        busy       = (cnt != '0) || out_valid || flush_pend;
    end

    // Output register: loads a full or flushed word, otherwise clears
    // valid when the presented word is accepted.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            out_data   <= '0;
            out_cnt    <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            word_count <= '0;
        end else begin
            if (accept) begin
                word_count <= word_count + 16'd1;
            end
            if (word_done) begin
                out_data  <= {fifo_rd_data, acc};
                out_cnt   <= FULL_CNT;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
            end else if (flush_emit) begin
                out_data  <= {{DATA_W{1'b0}}, acc};
                out_cnt   <= cnt;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Accumulator, fill index and sticky flush request.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (word_done || flush_emit) begin
                acc <= '0;
                cnt <= '0;
            end else if (pop) begin
                for (int k = 0; k < NIBBLES - 1; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        acc[k*DATA_W +: DATA_W] <= fifo_rd_data;
                    end
                end
                cnt <= cnt + CNT_W'(1);
            end
            // Repeated pulses while pending simply keep the bit set.
            flush_pend <= (flush_pend && !flush_done) || flush;
        end
    end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: a queue-backed show-ahead FIFO feeds the
// DUT; a stream-level model chunks pushed nibbles into expected words and a
// monitor compares every presented word against the expected queue.
module tb_fifo_nibble_packer;

    localparam int DATA_W  = 4;
    localparam int NIBBLES = 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);
    localparam int WORD_W  = DATA_W * NIBBLES;
    localparam int W       = WORD_W + CNT_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstN;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic              flush;
    logic [WORD_W-1:0] out_data;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [15:0]       word_count;

    fifo_nibble_packer #(.DATA_W(DATA_W), .NIBBLES(NIBBLES)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_data     (out_data),
        .out_cnt      (out_cnt),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .word_count   (word_count)
    );

    // ---------------- state ----------------
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] model_q[$];
    logic [W-1:0]      exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    logic              pop_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Stream view: every NIBBLES pushed nibbles make one word; a flush
    // closes whatever is left as a zero-padded partial word.
    task automatic emit_word(input logic last);
        logic [WORD_W-1:0] d;
        d = '0;
        for (int i = 0; i < model_q.size(); i++)
            d = d | (WORD_W'(model_q[i]) << (i * DATA_W));
        exp_q.push_back({d, CNT_W'(model_q.size()), last});
        model_q.delete();
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic refresh();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    // Called at posedge+1; samples the read strobe before the next edge,
    // then applies the pop to the FIFO model after it.
    task automatic step();
        logic [DATA_W-1:0] t;
        #2;
        pop_s = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop_s) begin
            check("pop_nonempty", 64'(fifo_q.size() != 0), 64'd1);
            if (fifo_q.size() != 0) t = fifo_q.pop_front();
        end
        refresh();
    endtask

    task automatic push(input logic [DATA_W-1:0] n);
        fifo_q.push_back(n);
        model_q.push_back(n);
        if (model_q.size() == NIBBLES) emit_word(1'b0);
        refresh();
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        if (model_q.size() != 0) emit_word(1'b1);
        step();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit, input bit rnd);
        int i;
        i = 0;
        while ((busy || fifo_q.size() != 0) && i < limit) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            step();
            i++;
        end
        if (busy || fifo_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, limit);
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int i;
        i = 0;
        while (!out_valid && i < limit) begin
            step();
            i++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL %s: out_valid=0 after %0d cycles, required 1", name, limit);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstN && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %0h expected none", {out_data, out_cnt, out_last});
                end else begin
                    check("word", 64'({out_data, out_cnt, out_last}), 64'(exp_q[0]));
                    if (out_ready) exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rstN      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_q.push_back(4'hF);
        refresh();

        // Reset with a non-empty FIFO: no pops, all outputs cleared.
        #2;
        check("rd_en_in_reset0", 64'(fifo_rd_en), 64'd0);
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        #2;
        check("rd_en_in_reset1", 64'(fifo_rd_en), 64'd0);
        @(posedge clk);
        #1;
        check("rst_fifo_untouched", 64'(fifo_q.size()), 64'd1);
        fifo_q.delete();
        refresh();
        rstN = 1'b1;

        // Single word.
        out_ready = 1'b1;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_rd_en", 64'(pop_s), 64'd1);
        end
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'h4321);
        check("single_cnt", 64'(out_cnt), 64'd4);
        check("single_last", 64'(out_last), 64'd0);
        step();
        check("single_valid_drop", 64'(out_valid), 64'd0);
        check("single_wc", 64'(word_count), 64'd1);

        // Backpressure.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(DATA_W'(i));
        repeat (12) step();
        check("bp_rd_en_low", 64'(pop_s), 64'd0);
        check("bp_fifo_left", 64'(fifo_q.size()), 64'd1);
        check("bp_hold_data", 64'(out_data), 64'h3210);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check("bp_pop_at_accept", 64'(pop_s), 64'd1);
        check("bp_next_data", 64'(out_data), 64'h7654);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_wc_mid", 64'(word_count), 64'd2);
        step();
        check("bp_wc", 64'(word_count), 64'd3);

        // Partial flush with FIFO drained.
        push(4'hA); push(4'hB);
        repeat (3) step();
        flush_pulse();
        step();
        check("pf_valid", 64'(out_valid), 64'd1);
        check("pf_data", 64'(out_data), 64'h00BA);
        check("pf_cnt", 64'(out_cnt), 64'd2);
        check("pf_last", 64'(out_last), 64'd1);
        step();

        // Flush while a nibble is still queued: C is popped first.
        push(4'hA); push(4'hB); push(4'hC);
        flush_pulse();
        wait_valid("pfq_wait", 20);
        check("pfq_data", 64'(out_data), 64'h0CBA);
        check("pfq_cnt", 64'(out_cnt), 64'd3);
        check("pfq_last", 64'(out_last), 64'd1);
        step();

        // Empty flush.
        wait_idle("ef_idle", 20, 1'b0);
        flush_pulse();
        check("ef_no_valid0", 64'(out_valid), 64'd0);
        step();
        check("ef_no_valid1", 64'(out_valid), 64'd0);
        check("ef_busy", 64'(busy), 64'd0);

        // Reset mid-operation.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) push(DATA_W'(i));
        repeat (10) step();
        check("rm_busy_before", 64'(busy), 64'd1);
        rstN = 1'b0;
        model_reset();
        step();
        check("rm_valid", 64'(out_valid), 64'd0);
        check("rm_data", 64'(out_data), 64'd0);
        check("rm_cnt", 64'(out_cnt), 64'd0);
        check("rm_last", 64'(out_last), 64'd0);
        check("rm_wc", 64'(word_count), 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        rstN = 1'b1;
        out_ready = 1'b1;
        push(4'h9); push(4'h8); push(4'h7); push(4'h6);
        wait_valid("rm_wait", 20);
        check("rm_new_data", 64'(out_data), 64'h6789);
        step();
        check("rm_new_wc", 64'(word_count), 64'd1);

        // Randomized traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) push(DATA_W'($urandom_range(0, 15)));
            if ($urandom_range(0, 59) == 0) begin
                flush_pulse();
                wait_idle("rand_flush_idle", 400, 1'b1);
            end else begin
                step();
            end
        end

        // Drain everything and confirm the scoreboard emptied.
        out_ready = 1'b1;
        flush_pulse();
        wait_idle("final_idle", 400, 1'b0);
        step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
